// File: rtl/clock_pkg.sv
// ============================================================================
// Module   : clock_pkg
// Brief    : Field widths, limits, time struct and helpers for digital_clock_hms.
// Revision : 1.0
// ============================================================================
`default_nettype none

package clock_pkg;

  localparam int HR_W  = 5;
  localparam int MIN_W = 6;
  localparam int SEC_W = 6;

  localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;
  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
  localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;

  typedef struct packed {
    logic [HR_W-1:0]  hours;
    logic [MIN_W-1:0] minutes;
    logic [SEC_W-1:0] seconds;
  } clock_time_t;

  function automatic logic time_valid(input clock_time_t t);
    return (t.hours <= HR_MAX) && (t.minutes <= MIN_MAX) && (t.seconds <= SEC_MAX);
  endfunction

  // Midnight shows as 12; afternoon hours fold down by 12.
  function automatic logic [HR_W-1:0] hours_12h(input logic [HR_W-1:0] h);
    if (h == '0)
      return 5'd12;
    else if (h > 5'd12)
      return h - 5'd12;
    else
      return h;
  endfunction

endpackage

`default_nettype wire

// File: rtl/clock_prescaler.sv
// ============================================================================
// Module   : clock_prescaler
// Brief    : Divides clk down to a one-per-second tick; clear restarts the count.
// Revision : 1.0
// ============================================================================
`default_nettype none

module clock_prescaler #(
  parameter int CLK_PER_SEC = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(CLK_PER_SEC - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_term;

  assign w_term = (r_cnt == TERM_CNT);
  assign tick   = en && w_term;

  always_ff @(posedge clk) begin
    if (reset || clear)
      r_cnt <= '0;
    else if (en)
      r_cnt <= w_term ? '0 : r_cnt + CNT_W'(1);
  end

endmodule

`default_nettype wire

// File: rtl/digital_clock_hms.sv
// ============================================================================
// Module   : digital_clock_hms
// Brief    : HH:MM:SS clock with load, 12/24 h display; CLOCK_ALARM_EN adds alarm.
// Revision : 1.0
// ============================================================================
`default_nettype none

module digital_clock_hms
  import clock_pkg::*;
#(
  parameter int CLK_PER_SEC = 10,
  parameter int START_24H   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [HR_W-1:0]  load_h,
  input  logic [MIN_W-1:0] load_m,
  input  logic [SEC_W-1:0] load_s,
  input  logic             mode_toggle,
`ifdef CLOCK_ALARM_EN
  input  logic             alarm_set,
  input  logic [HR_W-1:0]  alarm_h,
  input  logic [MIN_W-1:0] alarm_m,
  input  logic             alarm_arm,
  output logic             alarm_hit,
`endif
  output logic [SEC_W-1:0] seconds,
  output logic [MIN_W-1:0] minutes,
  output logic [HR_W-1:0]  hours,
  output logic             pm,
  output logic             tick_1s,
  output logic             day_wrap,
  output logic             load_err
);

  localparam logic            RST_MODE_24H = (START_24H != 0);
  localparam logic [HR_W-1:0] RST_HOURS    = RST_MODE_24H ? 5'd0 : 5'd12;

  clock_time_t     r_time, w_next, w_load_time;
  logic            r_mode_24h, w_next_mode;
  logic [HR_W-1:0] r_hours_disp;
  logic            r_pm, r_tick, r_day_wrap, r_load_err;
  logic            w_tick, w_load_ok, w_adv, w_wrap;

  assign w_load_time = '{hours: load_h, minutes: load_m, seconds: load_s};
  assign w_load_ok   = load && time_valid(w_load_time);

  clock_prescaler #(
    .CLK_PER_SEC (CLK_PER_SEC)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .clear (w_load_ok),
    .tick  (w_tick)
  );

  // A valid load takes priority over a coincident tick.
  assign w_adv  = w_tick && !w_load_ok;
  assign w_wrap = w_adv && (r_time.hours == HR_MAX) && (r_time.minutes == MIN_MAX)
                  && (r_time.seconds == SEC_MAX);
  assign w_next_mode = r_mode_24h ^ mode_toggle;

  always_comb begin
    w_next = r_time;
    if (w_load_ok) begin
      w_next = w_load_time;
    end else if (w_adv) begin
      if (r_time.seconds == SEC_MAX) begin
        w_next.seconds = '0;
        if (r_time.minutes == MIN_MAX) begin
          w_next.minutes = '0;
          w_next.hours   = (r_time.hours == HR_MAX) ? '0 : r_time.hours + 5'd1;
        end else begin
          w_next.minutes = r_time.minutes + 6'd1;
        end
      end else begin
        w_next.seconds = r_time.seconds + 6'd1;
      end
    end
  end

  // Display hours and pm are registered from next-state so every output is a flop.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_time       <= '0;
      r_mode_24h   <= RST_MODE_24H;
      r_hours_disp <= RST_HOURS;
      r_pm         <= 1'b0;
      r_tick       <= 1'b0;
      r_day_wrap   <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      r_time       <= w_next;
      r_mode_24h   <= w_next_mode;
      r_hours_disp <= w_next_mode ? w_next.hours : hours_12h(w_next.hours);
      r_pm         <= (w_next.hours >= 5'd12);
      r_tick       <= w_adv;
      r_day_wrap   <= w_wrap;
      r_load_err   <= load && !w_load_ok;
    end
  end

  assign seconds  = r_time.seconds;
  assign minutes  = r_time.minutes;
  assign hours    = r_hours_disp;
  assign pm       = r_pm;
  assign tick_1s  = r_tick;
  assign day_wrap = r_day_wrap;
  assign load_err = r_load_err;

`ifdef CLOCK_ALARM_EN
  logic [HR_W-1:0]  r_alarm_h;
  logic [MIN_W-1:0] r_alarm_m;
  logic             r_alarm_hit, w_alarm_match;

  assign w_alarm_match = alarm_arm && (w_adv || w_load_ok)
                         && (w_next.hours == r_alarm_h) && (w_next.minutes == r_alarm_m)
                         && (w_next.seconds == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_alarm_h   <= '0;
      r_alarm_m   <= '0;
      r_alarm_hit <= 1'b0;
    end else begin
      if (alarm_set && (alarm_h <= HR_MAX) && (alarm_m <= MIN_MAX)) begin
        r_alarm_h <= alarm_h;
        r_alarm_m <= alarm_m;
      end
      r_alarm_hit <= w_alarm_match;
    end
  end

  assign alarm_hit = r_alarm_hit;
`endif

endmodule

`default_nettype wire
